// File: rtl/lfsr_range_rng.sv
// Fibonacci LFSR with seed load and zero-lockup guard, serving bounded random
// numbers in [0, range) through rejection sampling with a capped retry count.
module lfsr_range_rng #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(32'hEA000001),
    parameter int                OUT_W     = 16,
    parameter int                MAX_TRIES = 8,
    parameter int                FREE_RUN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  seed_i,
    input  logic              seed_v,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [OUT_W-1:0]  req_range_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [OUT_W-1:0]  rsp_data_o,
    output logic              rsp_fallback_o,
    output logic [WIDTH-1:0]  lfsr_o
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   lfsr_reg;
    logic [WIDTH-1:0]   lfsr_next;
    logic [WIDTH-1:0]   lfsr_step;
    logic [WIDTH-1:0]   lfsr_cand;
    logic               lfsr_fb;
    logic               step_en;

    logic [OUT_W-1:0]   range_reg;
    logic [OUT_W-1:0]   mask_reg;
    logic [OUT_W-1:0]   range_m1;
    logic [OUT_W-1:0]   mask_in;
    logic [TRY_W-1:0]   try_cnt_reg;
    logic [OUT_W-1:0]   cand;
    logic               cand_ok;
    logic               last_try;
    logic [OUT_W-1:0]   rsp_data_reg;
    logic               rsp_fallback_reg;

    // ---------------- LFSR ----------------
    assign lfsr_fb   = ^(lfsr_reg & TAPS);
    assign lfsr_step = {lfsr_fb, lfsr_reg[WIDTH-1:1]};
    assign step_en   = (state_reg == S_GEN) || (FREE_RUN != 0);

    // Seed wins over stepping; an all-zero result is replaced by 1 to avoid lockup.
    always_comb begin
        lfsr_cand = lfsr_reg;
        if (seed_v) begin
            lfsr_cand = seed_i;
        end else if (step_en) begin
            lfsr_cand = lfsr_step;
        end
        lfsr_next = (lfsr_cand == '0) ? WIDTH'(1) : lfsr_cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= WIDTH'(1);
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    // ---------------- mask: smear MSB of (range-1) down to bit 0 ----------------
    assign range_m1 = req_range_i - OUT_W'(1);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_mask
            assign mask_in[gi] = |range_m1[OUT_W-1:gi];
        end
    endgenerate

    assign cand     = lfsr_reg[OUT_W-1:0] & mask_reg;
    assign cand_ok  = (range_reg == '0) || (cand < range_reg);
    assign last_try = (try_cnt_reg == TRY_W'(MAX_TRIES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (req_valid_i) state_next = S_GEN;
            S_GEN:  if (cand_ok || last_try) state_next = S_HOLD;
            S_HOLD: if (rsp_ready_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_reg == S_IDLE);
        rsp_valid_o = (state_reg == S_HOLD);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            range_reg        <= '0;
            mask_reg         <= '0;
            try_cnt_reg      <= '0;
            rsp_data_reg     <= '0;
            rsp_fallback_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid_i) begin
                        range_reg   <= req_range_i;
                        mask_reg    <= mask_in;
                        try_cnt_reg <= '0;
                    end
                end
                S_GEN: begin
                    if (cand_ok) begin
                        rsp_data_reg     <= cand;
                        rsp_fallback_reg <= 1'b0;
                    end else if (last_try) begin
                        // Dropping the top mask bit keeps the value strictly below range.
                        rsp_data_reg     <= cand & (mask_reg >> 1);
                        rsp_fallback_reg <= 1'b1;
                    end else begin
                        try_cnt_reg <= try_cnt_reg + TRY_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_data_o     = rsp_data_reg;
    assign rsp_fallback_o = rsp_fallback_reg;
    assign lfsr_o         = lfsr_reg;

endmodule
